// File: rtl/prio_enc_irq.sv
// prio_enc_irq: registered, parametrised priority encoder for active-low request lines.
//   Highest unmasked pending index wins. Requests are synchronised, can be masked per
//   line, and in latched mode short pulses are captured until acknowledged.
//
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   ei_n     - enable input, active low (1 forces idle outputs and ignores ack)
//   req_n    - N active-low request lines, asynchronous to clk
//   mask     - N line masks, 1 excludes the line from setting and encoding
//   mode     - 0 level (transparent), 1 latched-pending with ack handshake
//   ack      - acknowledge for the presented code, active high
//   code_n   - active-low index of the highest unmasked pending line
//   gs_n     - group select, 0 when code_n is valid
//   eo_n     - enable output, 0 when enabled and nothing pending (cascade)
//   pending  - pending register contents
module prio_enc_irq #(
    parameter int unsigned N           = 8,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned CW         = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ei_n,
    input  logic [N-1:0]  req_n,
    input  logic [N-1:0]  mask,
    input  logic          mode,
    input  logic          ack,
    output logic [CW-1:0] code_n,
    output logic          gs_n,
    output logic          eo_n,
    output logic [N-1:0]  pending
);

    typedef enum logic {StIdle = 1'b0, StHeld = 1'b1} ack_state_e;

    logic [N-1:0]  sync_q [SYNC_STAGES];
    logic [N-1:0]  sync_d [SYNC_STAGES];
    logic [N-1:0]  req_s;
    logic [N-1:0]  req_s_prev_q;
    logic [N-1:0]  rise;
    logic [N-1:0]  pend_q, pend_d;
    logic [N-1:0]  clr;
    logic [N-1:0]  cand;
    logic          win;
    logic [CW-1:0] win_idx;
    logic [CW-1:0] code_n_q, code_n_d;
    logic          gs_n_q, gs_n_d;
    logic          eo_n_q, eo_n_d;
    logic          ack_take;
    logic [CW-1:0] ack_idx;
    ack_state_e    ack_seen_q, ack_seen_d;

    // Synchroniser chain; idle (released) lines read as 1.
    always_comb begin
        sync_d[0] = req_n;
        for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign req_s = ~sync_q[SYNC_STAGES-1] & ~mask;
    assign rise  = req_s & ~req_s_prev_q;

    // Set is OR-ed in after the clear, so a coincident set wins.
    always_comb begin
        pend_d = req_s;
        if (mode) begin
            pend_d = (pend_q & ~clr) | rise;
        end
    end

    // Priority encode: the last match in ascending order is the highest index.
    always_comb begin
        cand    = pend_q & ~mask;
        win     = 1'b0;
        win_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cand[i]) begin
                win     = 1'b1;
                win_idx = CW'(i);
            end
        end
    end

    always_comb begin
        code_n_d = '1;
        gs_n_d   = 1'b1;
        eo_n_d   = 1'b1;
        if (!ei_n) begin
            if (win) begin
                code_n_d = ~win_idx;
                gs_n_d   = 1'b0;
            end else begin
                eo_n_d   = 1'b0;
            end
        end
    end

    // Ack handshake: one clear per ack assertion, only while a code is displayed.
    assign ack_take = (ack_seen_q == StIdle) && ack && !gs_n_q && mode && !ei_n;
    assign ack_idx  = ~code_n_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_seen_q <= StIdle;
        end else begin
            ack_seen_q <= ack_seen_d;
        end
    end

    always_comb begin
        ack_seen_d = ack_seen_q;
        unique case (ack_seen_q)
            StIdle:  if (ack_take) ack_seen_d = StHeld;
            StHeld:  if (!ack)     ack_seen_d = StIdle;
            default: ack_seen_d = StIdle;
        endcase
    end

    always_comb begin
        clr = '0;
        if (ack_take) begin
            clr = {{(N-1){1'b0}}, 1'b1} << ack_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '1;
            end
            req_s_prev_q <= '0;
            pend_q       <= '0;
            code_n_q     <= '1;
            gs_n_q       <= 1'b1;
            eo_n_q       <= 1'b1;
        end else begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            req_s_prev_q <= req_s;
            pend_q       <= pend_d;
            code_n_q     <= code_n_d;
            gs_n_q       <= gs_n_d;
            eo_n_q       <= eo_n_d;
        end
    end

    assign code_n  = code_n_q;
    assign gs_n    = gs_n_q;
    assign eo_n    = eo_n_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_prio_enc_irq.sv
// tb_prio_enc_irq: directed, self-checking bench for prio_enc_irq at N=8, SYNC_STAGES=2.
module tb_prio_enc_irq;

    logic       clk;
    logic       rst_n;
    logic       ei_n;
    logic [7:0] req_n;
    logic [7:0] mask;
    logic       mode;
    logic       ack;
    logic [2:0] code_n;
    logic       gs_n;
    logic       eo_n;
    logic [7:0] pending;

    int checks = 0;
    int errors = 0;

    prio_enc_irq #(
        .N           (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ei_n    (ei_n),
        .req_n   (req_n),
        .mask    (mask),
        .mode    (mode),
        .ack     (ack),
        .code_n  (code_n),
        .gs_n    (gs_n),
        .eo_n    (eo_n),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ei_n = 1'b0; req_n = 8'hFF; mask = 8'h00; mode = 1'b0; ack = 1'b0;
        #12;
        checks++; if (code_n !== 3'b111) begin errors++; $display("FAIL reset_code: got %b expected 111", code_n); end
        checks++; if (gs_n !== 1'b1) begin errors++; $display("FAIL reset_gs: got %b expected 1", gs_n); end
        checks++; if (eo_n !== 1'b1) begin errors++; $display("FAIL reset_eo: got %b expected 1", eo_n); end
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h expected 00", pending); end
        rst_n = 1'b1;
        tick(1);
        checks++; if (eo_n !== 1'b0) begin errors++; $display("FAIL reset_release_eo: got %b expected 0", eo_n); end
    endtask

    task automatic test_level;
        req_n = 8'b0110_1111;
        tick(3);
        checks++; if (gs_n !== 1'b1) begin errors++; $display("FAIL level_latency_gs: got %b expected 1", gs_n); end
        checks++; if (pending !== 8'h90) begin errors++; $display("FAIL level_pending: got %h expected 90", pending); end
        tick(1);
        checks++; if (code_n !== 3'b000) begin errors++; $display("FAIL level_code7: got %b expected 000", code_n); end
        checks++; if (gs_n !== 1'b0) begin errors++; $display("FAIL level_gs: got %b expected 0", gs_n); end
        checks++; if (eo_n !== 1'b1) begin errors++; $display("FAIL level_eo: got %b expected 1", eo_n); end
        req_n = 8'b1110_1111;
        tick(4);
        checks++; if (code_n !== 3'b011) begin errors++; $display("FAIL level_code4: got %b expected 011", code_n); end
    endtask

    task automatic test_enable;
        req_n = 8'hFF;
        tick(4);
        checks++; if (eo_n !== 1'b0) begin errors++; $display("FAIL en_idle_eo: got %b expected 0", eo_n); end
        checks++; if (gs_n !== 1'b1) begin errors++; $display("FAIL en_idle_gs: got %b expected 1", gs_n); end
        ei_n = 1'b1;
        tick(1);
        checks++; if (eo_n !== 1'b1) begin errors++; $display("FAIL dis_eo: got %b expected 1", eo_n); end
        checks++; if (code_n !== 3'b111) begin errors++; $display("FAIL dis_code: got %b expected 111", code_n); end
        // Pending still tracks requests while disabled.
        req_n = 8'b1110_1111;
        tick(4);
        checks++; if (pending !== 8'h10) begin errors++; $display("FAIL dis_pending: got %h expected 10", pending); end
        checks++; if (gs_n !== 1'b1) begin errors++; $display("FAIL dis_req_gs: got %b expected 1", gs_n); end
        ei_n = 1'b0;
        tick(1);
        checks++; if (code_n !== 3'b011) begin errors++; $display("FAIL reen_code: got %b expected 011", code_n); end
        checks++; if (gs_n !== 1'b0) begin errors++; $display("FAIL reen_gs: got %b expected 0", gs_n); end
        req_n = 8'hFF;
        tick(4);
    endtask

    task automatic test_latched;
        mode = 1'b1;
        tick(1);
        req_n = 8'b1111_1011;
        tick(3);
        req_n = 8'hFF;
        tick(6);
        checks++; if (pending !== 8'h04) begin errors++; $display("FAIL latch_pending: got %h expected 04", pending); end
        checks++; if (code_n !== 3'b101) begin errors++; $display("FAIL latch_code: got %b expected 101", code_n); end
        tick(5);
        checks++; if (code_n !== 3'b101) begin errors++; $display("FAIL latch_persist: got %b expected 101", code_n); end
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL ack_pending: got %h expected 00", pending); end
        checks++; if (gs_n !== 1'b0) begin errors++; $display("FAIL ack_lag_gs: got %b expected 0", gs_n); end
        tick(1);
        checks++; if (gs_n !== 1'b1) begin errors++; $display("FAIL ack_gs: got %b expected 1", gs_n); end
        checks++; if (eo_n !== 1'b0) begin errors++; $display("FAIL ack_eo: got %b expected 0", eo_n); end
    endtask

    task automatic test_held_ack;
        req_n = 8'b1101_0111;
        tick(2);
        req_n = 8'hFF;
        tick(6);
        checks++; if (pending !== 8'h28) begin errors++; $display("FAIL held_pending0: got %h expected 28", pending); end
        checks++; if (code_n !== 3'b010) begin errors++; $display("FAIL held_code5: got %b expected 010", code_n); end
        ack = 1'b1;
        tick(10);
        checks++; if (pending !== 8'h08) begin errors++; $display("FAIL held_pending1: got %h expected 08", pending); end
        checks++; if (code_n !== 3'b100) begin errors++; $display("FAIL held_code3: got %b expected 100", code_n); end
        ack = 1'b0;
        tick(1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL held_pending2: got %h expected 00", pending); end
        tick(1);
        checks++; if (gs_n !== 1'b1) begin errors++; $display("FAIL held_gs: got %b expected 1", gs_n); end
    endtask

    task automatic test_mask;
        mode = 1'b0;
        mask = 8'h40;
        req_n = 8'b1011_1101;
        tick(4);
        checks++; if (code_n !== 3'b110) begin errors++; $display("FAIL mask_code1: got %b expected 110", code_n); end
        checks++; if (pending !== 8'h02) begin errors++; $display("FAIL mask_pending: got %h expected 02", pending); end
        mask = 8'h00;
        tick(2);
        checks++; if (code_n !== 3'b001) begin errors++; $display("FAIL mask_code6: got %b expected 001", code_n); end
        req_n = 8'hFF;
        tick(4);
    endtask

    task automatic test_mask_latched;
        mode = 1'b1;
        tick(1);
        req_n = 8'b1011_1111;
        tick(2);
        req_n = 8'hFF;
        tick(6);
        checks++; if (code_n !== 3'b001) begin errors++; $display("FAIL mlatch_code: got %b expected 001", code_n); end
        mask = 8'h40;
        tick(1);
        checks++; if (gs_n !== 1'b1) begin errors++; $display("FAIL mlatch_masked_gs: got %b expected 1", gs_n); end
        checks++; if (eo_n !== 1'b0) begin errors++; $display("FAIL mlatch_masked_eo: got %b expected 0", eo_n); end
        checks++; if (pending !== 8'h40) begin errors++; $display("FAIL mlatch_kept: got %h expected 40", pending); end
        mask = 8'h00;
        tick(1);
        checks++; if (code_n !== 3'b001) begin errors++; $display("FAIL mlatch_back: got %b expected 001", code_n); end
        // Ack while disabled must not clear.
        ei_n = 1'b1;
        ack = 1'b1;
        tick(2);
        ack = 1'b0;
        checks++; if (pending !== 8'h40) begin errors++; $display("FAIL ack_disabled: got %h expected 40", pending); end
        ei_n = 1'b0;
        tick(1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(1);
    endtask

    task automatic test_reset_mid;
        req_n = 8'b1101_1011;
        tick(2);
        req_n = 8'hFF;
        tick(6);
        checks++; if (pending !== 8'h24) begin errors++; $display("FAIL mid_pending: got %h expected 24", pending); end
        checks++; if (code_n !== 3'b010) begin errors++; $display("FAIL mid_code: got %b expected 010", code_n); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (pending !== 8'h00) begin errors++; $display("FAIL mid_rst_pending: got %h expected 00", pending); end
        checks++; if (code_n !== 3'b111) begin errors++; $display("FAIL mid_rst_code: got %b expected 111", code_n); end
        checks++; if (gs_n !== 1'b1) begin errors++; $display("FAIL mid_rst_gs: got %b expected 1", gs_n); end
        checks++; if (eo_n !== 1'b1) begin errors++; $display("FAIL mid_rst_eo: got %b expected 1", eo_n); end
        #2 rst_n = 1'b1;
        tick(1);
        checks++; if (eo_n !== 1'b0) begin errors++; $display("FAIL mid_release_eo: got %b expected 0", eo_n); end
    endtask

    initial begin
        test_reset();
        test_level();
        test_enable();
        test_latched();
        test_held_ack();
        test_mask();
        test_mask_latched();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prio_enc_irq.md
Name: prio_enc_irq

Overview:
- Parametrised, registered successor of the 8-3 priority encoder: N active-low request lines, highest index wins.
- Adds input synchronisers, per-line mask, and a latched-pending mode with acknowledge handshake, so short switch/button pulses are captured and serviced in order.
- Sits between board switches/buttons and the LED/display logic. Keeps active-low cascade pins (ei_n, eo_n, gs_n) so instances chain like the TTL part.

Parameters:
- N, 8: number of request inputs (2..64).
- SYNC_STAGES, 2: synchroniser flops per request line (>=2).
- CW: derived as clog2(N). Not overridable.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ei_n  in  1  enable input, active low; 1 disables encoding.
- req_n  in  N  request lines, active low, asynchronous to clk.
- mask  in  N  1 = line excluded from setting and encoding.
- mode  in  1  0 = level (transparent) mode, 1 = latched-pending mode.
- ack  in  1  acknowledge for the currently presented code, synchronous, active high.
- code_n  out  CW  active-low index of highest unmasked pending line.
- gs_n  out  1  group select, 0 when code_n is valid.
- eo_n  out  1  enable output, 0 when enabled and nothing pending (cascade to lower-priority stage).
- pending  out  N  pending register, for LED display.

Behaviour:
- Reset (async, rst_n=0): synchroniser flops = all 1, previous-sample reg = 0, pend = 0, ack_seen = 0, code_n = all 1, gs_n = 1, eo_n = 1, pending = 0. Reset may assert at any cycle and takes effect immediately; no partial state survives.
- Sync: req_n passes through SYNC_STAGES flops. Define req_s = ~req_n_sync & ~mask.
- Level mode (mode=0): pend <= req_s every edge.
- Latched mode (mode=1):
  - pend <= (pend & ~clr) | rise, where rise = req_s & ~req_s_prev.
  - If set and clear hit the same bit in one cycle, set wins.
  - Mode switch 0->1 keeps the current pend contents. Switch 1->0 overwrites pend with req_s on the next edge.
- Mask: masked lines neither set pend nor take part in encoding. Their stored pend bits are kept and reappear when unmasked (latched mode).
- Encoding: winner = highest index i with pend[i] & ~mask[i]. Output regs update every edge:
  - ei_n=0 and winner exists: code_n = ~i, gs_n = 0, eo_n = 1.
  - ei_n=0 and no winner: code_n = all 1, gs_n = 1, eo_n = 0.
  - ei_n=1: code_n = all 1, gs_n = 1, eo_n = 1. pend still updates; ack is ignored.
- Latency: a req_n change reaches the outputs SYNC_STAGES+2 edges later (4 edges at default).
- Ack handshake (2-state FSM: IDLE, HELD):
  - IDLE, ack=1, gs_n=0, mode=1: clr = onehot(~code_n), i.e. the displayed index, cleared on that edge. Go to HELD.
  - HELD: no clearing. Return to IDLE when ack=0.
  - Exactly one clear per ack assertion, whatever its length.
  - ack while gs_n=1 or mode=0: no effect, stays IDLE.
  - Outputs reflect the clear 1 edge after the clearing edge.
- Width: code_n carries CW bits. When N is not a power of 2, unused codes never appear.

Test Plan:
- Reset mid-run: latched mode with pending=8'h24, pull rst_n low off-edge -> code_n=3'b111, gs_n=1, eo_n=1, pending=0 immediately. After release with all req_n=1, ei_n=0 -> eo_n=0 within 1 edge.
- Level priority (N=8): ei_n=0, mode=0, req_n=8'b0110_1111 -> 4 edges later code_n=3'b000, gs_n=0. Release bit 7 -> code_n=3'b011.
- Enable/cascade: all req_n=1 -> ei_n=0 gives eo_n=0, gs_n=1. ei_n=1 gives eo_n=1, gs_n=1, code_n=3'b111.
- Latched capture: mode=1, req_n[2] low 3 cycles then high -> pending=8'h04, code_n=3'b101 persists. One-cycle ack -> pending=0, gs_n=1, eo_n=0 one edge after the clear.
- Held ack: pending bits 5 and 3, ack high 10 cycles -> only bit 5 cleared, code_n=3'b100. Drop ack, pulse again -> bit 3 cleared.
- Mask: mode=0, req_n[6]=0 and req_n[1]=0, mask=8'h40 -> code_n=3'b110. Clear mask -> code_n=3'b001.
